// File: rtl/conv3x3_pkg.sv
// Shared RGB565 field layout, pixel type and channel helpers for the 3x3 stream filter.
package conv3x3_pkg;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned R_W   = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_W   = 5;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // Unpack a raw 16-bit word into its colour fields.
    function automatic rgb565_t to_rgb(input logic [PIX_W-1:0] d);
        rgb565_t p;
        p.r = d[R_LSB +: R_W];
        p.g = d[G_LSB +: G_W];
        p.b = d[B_LSB +: B_W];
        return p;
    endfunction

    // Clamp a signed channel result into 0 .. 2^w-1.
    function automatic logic [5:0] clamp_chan(input int v, input int unsigned w);
        int max_v;
        max_v = int'((32'd1 << w) - 32'd1);
        if (v < 0)
            return 6'd0;
        else if (v > max_v)
            return 6'(max_v);
        else
            return 6'(v);
    endfunction

endpackage

// File: rtl/conv3x3_line_buffer.sv
// One image line of pixel storage: combinational read of the old word, write of the new
// word at the same address on each accepted pixel. Contents are intentionally not reset.
module conv3x3_line_buffer #(
    parameter int unsigned DEPTH  = 240,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       rd_data_c
);

    logic [15:0] mem [DEPTH];

    assign rd_data_c = mem[addr];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wr_data;
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over RGB565 pixels with ready/valid handshakes on both sides.
// Define CONV3X3_SAT_EN to clamp channel results; otherwise they wrap modulo 2^width.
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 240,
    parameter int          W_CORNER   = 0,
    parameter int          W_EDGE     = -1,
    parameter int          W_CENTER   = 4,
    parameter int unsigned SHIFT      = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data
);

    localparam int unsigned COL_W = $clog2(LINE_WIDTH);

    logic [COL_W-1:0] col;
    logic [1:0]       row;
    logic [COL_W-1:0] eff_col_c;
    logic [1:0]       eff_row_c;
    logic             accept_c;
    logic             emit_c;
    logic             last_col_c;
    logic [15:0]      mid_px_c;
    logic [15:0]      top_px_c;
    rgb565_t          win [3][3];
    logic             win_valid;
    rgb565_t          res_c;

    // Output stage frees up when empty or draining; the window stage moves in lockstep.
    assign s_ready    = !m_valid || m_ready;
    assign accept_c   = s_valid && s_ready;
    assign eff_col_c  = s_sof ? '0 : col;
    assign eff_row_c  = s_sof ? 2'd0 : row;
    assign last_col_c = (eff_col_c == COL_W'(LINE_WIDTH - 1));
    assign emit_c     = (eff_row_c == 2'd2) && (eff_col_c >= COL_W'(2));

    // Raster position of the next pixel; row saturates once two full lines are buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= 2'd0;
        end else if (accept_c) begin
            if (last_col_c) begin
                col <= '0;
                row <= (eff_row_c == 2'd2) ? 2'd2 : eff_row_c + 2'd1;
            end else begin
                col <= eff_col_c + COL_W'(1);
                row <= eff_row_c;
            end
        end
    end

    conv3x3_line_buffer #(
        .DEPTH  (LINE_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb_mid (
        .clk       (clk),
        .we        (accept_c),
        .addr      (eff_col_c),
        .wr_data   (s_data),
        .rd_data_c (mid_px_c)
    );

    conv3x3_line_buffer #(
        .DEPTH  (LINE_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb_top (
        .clk       (clk),
        .we        (accept_c),
        .addr      (eff_col_c),
        .wr_data   (mid_px_c),
        .rd_data_c (top_px_c)
    );

    // Window rows are top/mid/bottom lines; column 2 holds the newest pixel.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= to_rgb(top_px_c);
            win[1][2] <= to_rgb(mid_px_c);
            win[2][2] <= to_rgb(s_data);
        end
    end

    // A pending window result is consumed whenever the output register advances.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            win_valid <= 1'b0;
        else if (accept_c)
            win_valid <= emit_c;
        else if (s_ready)
            win_valid <= 1'b0;
    end

    function automatic int tap_mac(input logic [8:0][5:0] t);
        int corners;
        int edges;
        int acc;
        corners = int'(t[0]) + int'(t[2]) + int'(t[6]) + int'(t[8]);
        edges   = int'(t[1]) + int'(t[3]) + int'(t[5]) + int'(t[7]);
        acc     = W_CORNER * corners + W_EDGE * edges + W_CENTER * int'(t[4]);
        return acc >>> SHIFT;
    endfunction

    // Per-channel weighted sum, then saturate or wrap into the channel width.
    always_comb begin
        logic [8:0][5:0] r_taps;
        logic [8:0][5:0] g_taps;
        logic [8:0][5:0] b_taps;
        int              r_sum;
        int              g_sum;
        int              b_sum;
        r_taps = '0;
        g_taps = '0;
        b_taps = '0;
        res_c  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r_taps[i*3+j] = 6'(win[i][j].r);
                g_taps[i*3+j] = 6'(win[i][j].g);
                b_taps[i*3+j] = 6'(win[i][j].b);
            end
        end
        r_sum = tap_mac(r_taps);
        g_sum = tap_mac(g_taps);
        b_sum = tap_mac(b_taps);
`ifdef CONV3X3_SAT_EN
        res_c.r = R_W'(clamp_chan(r_sum, R_W));
        res_c.g = G_W'(clamp_chan(g_sum, G_W));
        res_c.b = B_W'(clamp_chan(b_sum, B_W));
`else
        res_c.r = R_W'(r_sum);
        res_c.g = G_W'(g_sum);
        res_c.b = B_W'(b_sum);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (s_ready) begin
            m_valid <= win_valid;
            m_data  <= res_c;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream with an 8-pixel line and default weights.
module tb_conv3x3_stream;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] img [0:3][0:LW-1];
    logic [15:0] got_q [$];

    always #5 clk = ~clk;

    conv3x3_stream #(.LINE_WIDTH(LW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    // Inputs and m_ready only change just after posedge, so a negedge view predicts the transfer.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready)
            got_q.push_back(m_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int chan(input logic [15:0] p, input int ch);
        case (ch)
            0:       return int'(p[15:11]);
            1:       return int'(p[10:5]);
            default: return int'(p[4:0]);
        endcase
    endfunction

    // Reference for centre (r,c) with corner 0, edge -1, centre 4, no shift.
    function automatic logic [15:0] model_px(input int r, input int c);
        logic [15:0] res;
        int          v;
        int          max_v;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = 4 * chan(img[r][c], ch) - chan(img[r-1][c], ch) - chan(img[r+1][c], ch)
                - chan(img[r][c-1], ch) - chan(img[r][c+1], ch);
            max_v = (ch == 1) ? 63 : 31;
`ifdef CONV3X3_SAT_EN
            if (v < 0) v = 0;
            if (v > max_v) v = max_v;
`endif
            v = v & max_v;
            case (ch)
                0:       res[15:11] = 5'(v);
                1:       res[10:5]  = 6'(v);
                default: res[4:0]   = 5'(v);
            endcase
        end
        return res;
    endfunction

    task automatic send_px(input logic [15:0] d, input logic sof);
        int waited;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 200) begin
                check_eq("s_ready_wait", 32'(s_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_row(input int r, input int c0, input int c1, input logic sof);
        for (int c = c0; c <= c1; c++)
            send_px(img[r][c], sof && (c == c0));
    endtask

    task automatic send_frame();
        for (int r = 0; r < 4; r++)
            send_row(r, 0, LW - 1, r == 0);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int n);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(model_px(1 + i / 6, 1 + i % 6)));
    endtask

    task automatic fill_img(input int seed);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 16'((r * LW + c) * 16'h0923 + seed);
    endtask

    task automatic stall_once();
        int          guard;
        int          idx;
        logic [15:0] exp;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!m_valid && guard < 100);
        check_eq("stall_seen_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b0;
        idx = got_q.size();
        exp = model_px(1 + idx / 6, 1 + idx % 6);
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_m_data", 32'(m_data), 32'(exp));
            check_eq("stall_m_valid", 32'(m_valid), 32'd1);
            check_eq("stall_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        #12;
        check_eq("reset_m_valid", 32'(m_valid), 32'd0);
        check_eq("reset_s_ready", 32'(s_ready), 32'd1);
        check_eq("reset_m_data", 32'(m_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Flat grey frame: every interior result is zero.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 16'h8410;
        got_q.delete();
        send_frame();
        drain();
        check_eq("flat_count", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < got_q.size(); i++)
            check_eq($sformatf("flat_%0d", i), 32'(got_q[i]), 32'h0000);

        // Single red impulse at (2,3).
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 16'h0000;
        img[2][3] = 16'hF800;
        got_q.delete();
        send_frame();
        drain();
`ifdef CONV3X3_SAT_EN
        check_eq("impulse_centre", 32'(got_q[8]), 32'hF800);
        check_eq("impulse_above", 32'(got_q[2]), 32'h0000);
`else
        check_eq("impulse_centre", 32'(got_q[8]), 32'hE000);
        check_eq("impulse_above", 32'(got_q[2]), 32'h0800);
`endif
        check_outputs("impulse", 12);

        // Backpressure mid-frame.
        fill_img(16'h1111);
        got_q.delete();
        fork
            send_frame();
            stall_once();
        join
        drain();
        check_outputs("stall", 12);

        // New frame marker arriving at column 4 of row 3.
        fill_img(16'h3C5A);
        got_q.delete();
        send_row(0, 0, LW - 1, 1'b1);
        send_row(1, 0, LW - 1, 1'b0);
        send_row(2, 0, LW - 1, 1'b0);
        send_row(3, 0, 3, 1'b0);
        drain();
        check_outputs("sof_old", 8);
        got_q.delete();
        fill_img(16'h7A03);
        send_row(0, 0, LW - 1, 1'b1);
        send_row(1, 0, LW - 1, 1'b0);
        send_row(2, 0, 1, 1'b0);
        drain();
        check_eq("sof_gap_count", 32'(got_q.size()), 32'd0);
        send_row(2, 2, LW - 1, 1'b0);
        drain();
        check_outputs("sof_new", 6);

        // Asynchronous reset with an output in flight.
        fill_img(16'h5555);
        got_q.delete();
        send_row(0, 0, LW - 1, 1'b1);
        send_row(1, 0, LW - 1, 1'b0);
        send_row(2, 0, 4, 1'b0);
        check_eq("rst_pre_valid", 32'(m_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_hold_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        @(posedge clk);
        #1;
        fill_img(16'h0ACE);
        send_row(0, 0, LW - 1, 1'b0);
        send_row(1, 0, LW - 1, 1'b0);
        send_row(2, 0, 1, 1'b0);
        drain();
        check_eq("rst_gap_count", 32'(got_q.size()), 32'd0);
        send_row(2, 2, 2, 1'b0);
        drain();
        check_outputs("rst_first", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
